// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data width, parity, stop bits) with parity/framing errors.
// Define UART_RX_BREAK_DETECT_EN to add the o_Break output for all-zero frames.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Rx_Busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 o_Break
`endif
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, CLEANUP} state_t;

    state_t               state;
    logic                 sync1, rx;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err, frm_err, par_bit, armed;
    logic                 at_mid, at_end;

    assign at_mid = cnt == CW'(MID);
    assign at_end = cnt == CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk, zero_stop;
    assign zero_stop = shreg == '0 && !par_bit && !rx;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= IDLE;
            sync1        <= 1'b1;
            rx           <= 1'b1;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            par_bit      <= 1'b0;
            armed        <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Rx_Busy    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk          <= 1'b0;
            o_Break      <= 1'b0;
`endif
        end else begin
            sync1 <= i_Rx_Serial;
            rx    <= sync1;
            case (state)
                IDLE: begin
                    // a stuck-low line must go high before a new start edge counts
                    armed <= armed | rx;
                    if (armed && !rx) begin
                        state     <= START;
                        cnt       <= '0;
                        o_Rx_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (at_mid) begin
                        cnt <= '0;
                        if (rx) begin
                            state     <= IDLE;
                            o_Rx_Busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            idx     <= '0;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                            par_bit <= 1'b0;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (at_end) begin
                        cnt   <= '0;
                        shreg <= {rx, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 4'(DATA_BITS - 1)) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                PAR: begin
                    if (at_end) begin
                        cnt     <= '0;
                        par_bit <= rx;
                        par_err <= (^shreg ^ rx) != (PARITY == 1);
                        state   <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (at_end) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        if (!rx)
                            frm_err <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (idx == 4'd0)
                            brk <= zero_stop;
`endif
                        if (idx == 4'(STOP_BITS - 1)) begin
                            state        <= CLEANUP;
                            o_Rx_DV      <= 1'b1;
                            o_Rx_Byte    <= shreg;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= frm_err | !rx;
`ifdef UART_RX_BREAK_DETECT_EN
                            o_Break      <= (idx == 4'd0) ? zero_stop : brk;
`endif
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                CLEANUP: begin
                    state     <= IDLE;
                    o_Rx_DV   <= 1'b0;
                    o_Rx_Busy <= 1'b0;
                    armed     <= rx;
`ifdef UART_RX_BREAK_DETECT_EN
                    o_Break   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg across four parameter sets.
module tb_uart_rx_cfg;
    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rx  = 4'hF;
    logic       dv0, dv1, dv2, dv3;
    logic       pe0, pe1, pe2, pe3;
    logic       fe0, fe1, fe2, fe3;
    logic       busy0, busy1, busy2, busy3;
    logic [7:0] byte0, byte1;
    logic [6:0] byte2;
    logic [8:0] byte3;
`ifdef UART_RX_BREAK_DETECT_EN
    logic [3:0] brk;
`endif

    int n0 = 0, n1 = 0, n2 = 0, n3 = 0, brk_cnt = 0;
    int vec = 0, errs = 0;
    logic [7:0] q0[$];

    always #50 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
        .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Rx_Busy(busy0)
`ifdef UART_RX_BREAK_DETECT_EN
        , .o_Break(brk[0])
`endif
    );
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
        .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Rx_Busy(busy1)
`ifdef UART_RX_BREAK_DETECT_EN
        , .o_Break(brk[1])
`endif
    );
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
        .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Rx_Busy(busy2)
`ifdef UART_RX_BREAK_DETECT_EN
        , .o_Break(brk[2])
`endif
    );
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1)) u3 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv3), .o_Rx_Byte(byte3),
        .o_Parity_Err(pe3), .o_Frame_Err(fe3), .o_Rx_Busy(busy3)
`ifdef UART_RX_BREAK_DETECT_EN
        , .o_Break(brk[3])
`endif
    );

    always @(negedge clk) begin
        if (dv0) begin
            n0++;
            q0.push_back(byte0);
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk[0]) brk_cnt++;
`endif
        end
        if (dv1) n1++;
        if (dv2) n2++;
        if (dv3) n3++;
    end

    // drives n bits of f LSB first onto line k, one bit period each, then idles high
    task automatic send(input int k, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx[k] = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx[k] = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 4'hF;
        repeat (3) @(negedge clk);
        vec++; if ({dv0, busy0, pe0, fe0} !== 4'b0) begin errs++; $display("FAIL reset_flags0 got %b want 0000", {dv0, busy0, pe0, fe0}); end
        vec++; if (byte0 !== 8'h00) begin errs++; $display("FAIL reset_byte0 got %h want 00", byte0); end
        vec++; if (byte3 !== 9'h000 || busy3 !== 1'b0) begin errs++; $display("FAIL reset_u3 got %h/%b want 000/0", byte3, busy3); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        int b = n0;
        int i;
        send(0, {8'h3F, 1'b0}, 9);
        for (i = 0; i < 150 && !dv0; i++) @(negedge clk);
        vec++; if (dv0 !== 1'b1) begin errs++; $display("FAIL basic_dv_timeout got %b want 1", dv0); end
        vec++; if (byte0 !== 8'h3F) begin errs++; $display("FAIL basic_byte got %h want 3f", byte0); end
        vec++; if ({pe0, fe0} !== 2'b00) begin errs++; $display("FAIL basic_errs got %b want 00", {pe0, fe0}); end
        vec++; if (busy0 !== 1'b1) begin errs++; $display("FAIL basic_busy_dv got %b want 1", busy0); end
        @(negedge clk);
        vec++; if ({dv0, busy0} !== 2'b00) begin errs++; $display("FAIL basic_after_dv got %b want 00", {dv0, busy0}); end
        repeat (CPB) @(negedge clk);
        vec++; if (n0 !== b + 1) begin errs++; $display("FAIL basic_dv_count got %0d want %0d", n0, b + 1); end
    endtask

    task automatic test_parity;
        int b1 = n1, b3 = n3;
        send(1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        vec++; if (n1 !== b1 + 1 || byte1 !== 8'hA5) begin errs++; $display("FAIL even_ok got %0d/%h want %0d/a5", n1, byte1, b1 + 1); end
        vec++; if ({pe1, fe1} !== 2'b00) begin errs++; $display("FAIL even_ok_errs got %b want 00", {pe1, fe1}); end
        send(1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        vec++; if (n1 !== b1 + 2 || byte1 !== 8'hA5) begin errs++; $display("FAIL even_bad got %0d/%h want %0d/a5", n1, byte1, b1 + 2); end
        vec++; if ({pe1, fe1} !== 2'b10) begin errs++; $display("FAIL even_bad_errs got %b want 10", {pe1, fe1}); end
        send(3, {1'b1, 1'b0, 9'h1A5, 1'b0}, 12);
        vec++; if (n3 !== b3 + 1 || byte3 !== 9'h1A5 || pe3 !== 1'b0) begin errs++; $display("FAIL odd9_ok got %0d/%h/%b want %0d/1a5/0", n3, byte3, pe3, b3 + 1); end
        send(3, {1'b1, 1'b1, 9'h1A5, 1'b0}, 12);
        vec++; if (n3 !== b3 + 2 || byte3 !== 9'h1A5 || pe3 !== 1'b1) begin errs++; $display("FAIL odd9_bad got %0d/%h/%b want %0d/1a5/1", n3, byte3, pe3, b3 + 2); end
    endtask

    task automatic test_two_stop;
        int b = n2;
        send(2, {1'b1, 7'h55, 1'b0}, 9);
        rx[2] = 1'b0;
        repeat (40) @(negedge clk);
        vec++; if (n2 !== b || busy2 !== 1'b1) begin errs++; $display("FAIL stop2_early got %0d/%b want %0d/1", n2, busy2, b); end
        repeat (CPB - 40) @(negedge clk);
        rx[2] = 1'b1;
        vec++; if (n2 !== b + 1 || byte2 !== 7'h55) begin errs++; $display("FAIL stop2_dv got %0d/%h want %0d/55", n2, byte2, b + 1); end
        vec++; if ({pe2, fe2} !== 2'b01) begin errs++; $display("FAIL stop2_errs got %b want 01", {pe2, fe2}); end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_glitch;
        int b = n0;
        rx[0] = 1'b0;
        repeat (20) @(negedge clk);
        vec++; if (busy0 !== 1'b1) begin errs++; $display("FAIL glitch_busy got %b want 1", busy0); end
        rx[0] = 1'b1;
        repeat (40) @(negedge clk);
        vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL glitch_idle got %b want 0", busy0); end
        repeat (100) @(negedge clk);
        vec++; if (n0 !== b) begin errs++; $display("FAIL glitch_no_dv got %0d want %0d", n0, b); end
        send(0, {1'b1, 8'hC3, 1'b0}, 10);
        vec++; if (n0 !== b + 1 || byte0 !== 8'hC3) begin errs++; $display("FAIL glitch_then_c3 got %0d/%h want %0d/c3", n0, byte0, b + 1); end
    endtask

    task automatic test_back_to_back;
        int b;
        q0.delete();
        send(0, {1'b1, 8'h01, 1'b0}, 10);
        send(0, {1'b1, 8'hFE, 1'b0}, 10);
        vec++;
        if (q0.size() != 2) begin
            errs++; $display("FAIL b2b_count got %0d want 2", q0.size());
        end else if (q0[0] !== 8'h01 || q0[1] !== 8'hFE) begin
            errs++; $display("FAIL b2b_order got %h,%h want 01,fe", q0[0], q0[1]);
        end
        b = n0;
        send(0, {8'h5A, 1'b0}, 5);
        rx[0] = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if ({dv0, busy0, pe0, fe0} !== 4'b0 || byte0 !== 8'h00) begin errs++; $display("FAIL midreset_outs got %b/%h want 0000/00", {dv0, busy0, pe0, fe0}, byte0); end
        rx[0] = 1'b1;
        rst = 1'b0;
        repeat (6 * CPB) @(negedge clk);
        vec++; if (n0 !== b || busy0 !== 1'b0) begin errs++; $display("FAIL midreset_no_dv got %0d/%b want %0d/0", n0, busy0, b); end
        send(0, {1'b1, 8'h81, 1'b0}, 10);
        vec++; if (n0 !== b + 1 || byte0 !== 8'h81 || fe0 !== 1'b0) begin errs++; $display("FAIL after_reset_81 got %0d/%h/%b want %0d/81/0", n0, byte0, fe0, b + 1); end
    endtask

    task automatic test_stuck_low;
        int b = n0, bb = brk_cnt;
        rx[0] = 1'b0;
        repeat (11 * CPB) @(negedge clk);
        vec++; if (n0 !== b + 1 || busy0 !== 1'b0) begin errs++; $display("FAIL stuck_dv got %0d/%b want %0d/0", n0, busy0, b + 1); end
        vec++; if (byte0 !== 8'h00 || {pe0, fe0} !== 2'b01) begin errs++; $display("FAIL stuck_vals got %h/%b want 00/01", byte0, {pe0, fe0}); end
        repeat (CPB) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        vec++; if (n0 !== b + 1) begin errs++; $display("FAIL stuck_no_restart got %0d want %0d", n0, b + 1); end
`ifdef UART_RX_BREAK_DETECT_EN
        vec++; if (brk_cnt !== bb + 1) begin errs++; $display("FAIL break_flag got %0d want %0d", brk_cnt, bb + 1); end
`else
        vec++; if (brk_cnt !== bb) begin errs++; $display("FAIL break_absent got %0d want %0d", brk_cnt, bb); end
`endif
        send(0, {1'b1, 8'h3C, 1'b0}, 10);
        vec++; if (n0 !== b + 2 || byte0 !== 8'h3C || fe0 !== 1'b0) begin errs++; $display("FAIL stuck_recover got %0d/%h/%b want %0d/3c/0", n0, byte0, fe0, b + 2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_glitch();
        test_back_to_back();
        test_stuck_low();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver used in the serial path. Supports configurable data width, parity mode and stop-bit count, and reports parity and framing errors. Sits between the asynchronous serial pin and the byte-consumer logic. Delivers one received word per frame with a single-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit period (10 MHz / 115200); legal 4..65535
DATA_BITS, 8, data bits per frame, LSB first; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
i_Clock  input  1  system clock
i_Reset  input  1  asynchronous, active-high reset
i_Rx_Serial  input  1  asynchronous serial line, idle high
o_Rx_DV  output  1  one-cycle strobe; o_Rx_Byte and error flags valid
o_Rx_Byte  output  DATA_BITS  received data word
o_Parity_Err  output  1  parity mismatch on the frame flagged by o_Rx_DV
o_Frame_Err  output  1  a sampled stop bit was 0 on the frame flagged by o_Rx_DV
o_Rx_Busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; bit counter and clock counter 0; synchroniser flops set to 1 (idle line).
- i_Rx_Serial passes through a 2-flop synchroniser; all decisions use the synchronised value (2-cycle input latency).
- Clock counter counts 0..CLKS_PER_BIT-1; "mid" = count (CLKS_PER_BIT-1)/2 (integer division).
- IDLE: synced line 0 -> START, counter cleared, o_Rx_Busy=1.
- START: at mid, line still 0 -> counter cleared, DATA (sampling then occurs every CLKS_PER_BIT cycles at bit centres). Line 1 at mid -> glitch; return to IDLE, no DV, no error.
- DATA: each centre sample shifts into bit index 0..DATA_BITS-1 (LSB first). After the last bit -> PARITY if PARITY!=0, else STOP.
- PARITY: centre sample compared against XOR of data bits; odd mode expects XOR(data, parity)=1, even expects 0. Mismatch latched internally.
- STOP: STOP_BITS centre samples; any 0 latches frame error. After the last stop sample -> CLEANUP.
- CLEANUP (one cycle): o_Rx_DV=1, o_Rx_Byte, o_Parity_Err and o_Frame_Err updated together; next cycle IDLE, o_Rx_DV=0, o_Rx_Busy=0.
- o_Rx_Byte and error flags hold their values until the next o_Rx_DV. Data is delivered even when an error flag is set.
- Latency: o_Rx_DV rises 2 (sync) + 1 (CLEANUP) cycles after the last stop-bit centre sample.
- Frame error with line held low: after CLEANUP, IDLE waits for the synced line to return high before arming start detection (no false restart on a stuck-low line).
- Back-to-back frames: a start edge in the cycle after CLEANUP is accepted; no idle time is required beyond the stop bit(s).
- DATA_BITS=9 with PARITY!=0 is legal (11-bit frame plus stop).
- Reset mid-frame: immediate abort, no DV; reception resumes on the next start edge after release.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined: adds output o_Break (1 bit, reset 0). A frame where all data bits, the parity bit (if present) and the first stop bit sample 0 asserts o_Break for one cycle together with o_Rx_DV (o_Frame_Err also 1). The receiver then waits for the line high, as above.
- Not defined: no o_Break port; such a frame reports only o_Frame_Err=1 with o_Rx_Byte=0.

Test Plan:
- Default params, send 0x3F 8N1 at 8700 ns/bit -> exactly one o_Rx_DV, o_Rx_Byte=0x3F, both error flags 0, o_Rx_Busy low one cycle after DV.
- PARITY=2, send 0xA5 with parity bit 0, then 0xA5 with parity bit 1 -> first frame o_Parity_Err=0; second frame o_Parity_Err=1, o_Rx_Byte=0xA5.
- DATA_BITS=7, STOP_BITS=2, send 0x55 with second stop bit 0 -> o_Rx_Byte=0x55, o_Frame_Err=1, DV only after the second stop centre.
- 20-cycle low glitch on an idle line -> no o_Rx_DV, o_Rx_Busy returns low by the START mid sample; then a clean 0xC3 frame -> 0xC3 received.
- Two back-to-back frames 0x01, 0xFE with no idle gap -> two DV pulses, values in order; assert i_Reset mid-way through a third frame -> no DV, outputs 0; a following frame 0x81 is received correctly.
- With UART_RX_BREAK_DETECT_EN, hold the line low for 12 bit times, then release -> one DV with o_Break=1, o_Frame_Err=1, o_Rx_Byte=0; no further DV until a new start edge.
